// File: rtl/game_pkg.sv
// Shared types and default constants for the game-state sequencer and the
// loser/winner sprite blocks.
package game_pkg;

    localparam int unsigned LIVES_W                = 2;
    localparam int unsigned STATE_W                = 3;
    localparam int unsigned DEF_START_LIVES        = 3;
    localparam int unsigned DEF_HIT_FRAMES         = 60;
    localparam int unsigned DEF_END_HOLD_FRAMES    = 180;
    localparam int unsigned DEF_AUTORESTART_FRAMES = 600;
    localparam int unsigned DEF_ALIEN_CNT_W        = 6;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_HIT  = 3'd2,
        ST_LOSE = 3'd3,
        ST_WIN  = 3'd4
    } game_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/game_status_ctrl_if.sv
// Gameplay event inputs and status outputs of the game-state sequencer.
interface game_status_ctrl_if
    import game_pkg::*;
#(
    parameter int unsigned ALIEN_CNT_W = DEF_ALIEN_CNT_W
);
    logic                   frame_tick;
    logic                   start;
    logic                   player_hit;
    logic                   invaders_landed;
    logic [ALIEN_CNT_W-1:0] aliens_left;
    logic                   playing;
    logic                   freeze;
    logic                   loser;
    logic                   winner;
    logic [LIVES_W-1:0]     lives;
    logic [STATE_W-1:0]     state_dbg;

    modport master (
        output frame_tick, start, player_hit, invaders_landed, aliens_left,
        input  playing, freeze, loser, winner, lives, state_dbg
    );

    modport slave (
        input  frame_tick, start, player_hit, invaders_landed, aliens_left,
        output playing, freeze, loser, winner, lives, state_dbg
    );
endinterface

// File: rtl/frame_timer.sv
// Saturating frame-tick counter with synchronous clear and terminal compares
// for the hit-freeze, end-hold and auto-restart intervals.
module frame_timer #(
    parameter int unsigned CNT_W              = 10,
    parameter int unsigned SAT_VAL            = 600,
    parameter int unsigned HIT_FRAMES         = 60,
    parameter int unsigned END_HOLD_FRAMES    = 180,
    parameter int unsigned AUTORESTART_FRAMES = 600
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic hit_done,
    output logic hold_done,
    output logic auto_done
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a coincident tick so a new state always starts at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick && (cnt_q < CNT_W'(SAT_VAL))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_done  = tick && (cnt_q == CNT_W'(HIT_FRAMES - 1));
    assign hold_done = (cnt_q >= CNT_W'(END_HOLD_FRAMES));
    assign auto_done = tick && (cnt_q == CNT_W'(AUTORESTART_FRAMES - 1));
endmodule

// File: rtl/game_status_ctrl.sv
// Game-state sequencer: IDLE/PLAY/HIT/LOSE/WIN with lives and frame timing.
// Define GAME_STATUS_AUTORESTART_EN to return from LOSE/WIN to IDLE unattended.
module game_status_ctrl
    import game_pkg::*;
#(
    parameter int unsigned START_LIVES        = DEF_START_LIVES,
    parameter int unsigned HIT_FRAMES         = DEF_HIT_FRAMES,
    parameter int unsigned END_HOLD_FRAMES    = DEF_END_HOLD_FRAMES,
    parameter int unsigned AUTORESTART_FRAMES = DEF_AUTORESTART_FRAMES,
    parameter int unsigned ALIEN_CNT_W        = DEF_ALIEN_CNT_W
) (
    input logic               clk,
    input logic               rst,
    game_status_ctrl_if.slave bus
);
    localparam int unsigned FCNT_MAX = max3(HIT_FRAMES, END_HOLD_FRAMES, AUTORESTART_FRAMES);
    localparam int unsigned FCNT_W   = $clog2(FCNT_MAX + 1);
    localparam int unsigned HOLD_SAT = (END_HOLD_FRAMES > AUTORESTART_FRAMES) ?
                                       END_HOLD_FRAMES : AUTORESTART_FRAMES;

    game_state_t        state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               playing_q, playing_d;
    logic               freeze_q, freeze_d;
    logic               loser_q, loser_d;
    logic               winner_q, winner_d;
    logic [STATE_W-1:0] state_dbg_q, state_dbg_d;
    logic               fcnt_clr;
    logic               hit_done, hold_done, auto_done;

    frame_timer #(
        .CNT_W              (FCNT_W),
        .SAT_VAL            (HOLD_SAT),
        .HIT_FRAMES         (HIT_FRAMES),
        .END_HOLD_FRAMES    (END_HOLD_FRAMES),
        .AUTORESTART_FRAMES (AUTORESTART_FRAMES)
    ) u_frame_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (fcnt_clr),
        .tick      (bus.frame_tick),
        .hit_done  (hit_done),
        .hold_done (hold_done),
        .auto_done (auto_done)
    );

`ifndef GAME_STATUS_AUTORESTART_EN
    logic unused_auto_done;
    assign unused_auto_done = auto_done;
`endif

    // Next state and lives; PLAY events are checked in priority order.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES_W'(START_LIVES);
                end
            end
            ST_PLAY: begin
                if (bus.invaders_landed) begin
                    state_d = ST_LOSE;
                    lives_d = '0;
                end else if (bus.player_hit) begin
                    if (lives_q <= LIVES_W'(1)) begin
                        state_d = ST_LOSE;
                        lives_d = '0;
                    end else begin
                        state_d = ST_HIT;
                        lives_d = lives_q - LIVES_W'(1);
                    end
                end else if (bus.aliens_left == '0) begin
                    state_d = ST_WIN;
                end
            end
            ST_HIT: begin
                if (bus.invaders_landed) begin
                    state_d = ST_LOSE;
                    lives_d = '0;
                end else if (hit_done) begin
                    state_d = ST_PLAY;
                end
            end
            ST_LOSE, ST_WIN: begin
                if (bus.start && hold_done) begin
                    state_d = ST_IDLE;
                end
`ifdef GAME_STATUS_AUTORESTART_EN
                else if (auto_done) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Every state change restarts the frame counter.
    assign fcnt_clr = (state_d != state_q);

    always_comb begin
        playing_d   = (state_d == ST_PLAY);
        freeze_d    = (state_d != ST_PLAY);
        loser_d     = (state_d == ST_LOSE);
        winner_d    = (state_d == ST_WIN);
        state_dbg_d = STATE_W'(state_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            lives_q     <= LIVES_W'(START_LIVES);
            playing_q   <= 1'b0;
            freeze_q    <= 1'b1;
            loser_q     <= 1'b0;
            winner_q    <= 1'b0;
            state_dbg_q <= '0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            playing_q   <= playing_d;
            freeze_q    <= freeze_d;
            loser_q     <= loser_d;
            winner_q    <= winner_d;
            state_dbg_q <= state_dbg_d;
        end
    end

    assign bus.playing   = playing_q;
    assign bus.freeze    = freeze_q;
    assign bus.loser     = loser_q;
    assign bus.winner    = winner_q;
    assign bus.lives     = lives_q;
    assign bus.state_dbg = state_dbg_q;
endmodule

// File: tb/tb_game_status_ctrl.sv
// Directed self-checking bench for game_status_ctrl with short frame intervals.
module tb_game_status_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    game_status_ctrl_if #(.ALIEN_CNT_W(6)) bus ();

    game_status_ctrl #(
        .START_LIVES        (3),
        .HIT_FRAMES         (4),
        .END_HOLD_FRAMES    (8),
        .AUTORESTART_FRAMES (12),
        .ALIEN_CNT_W        (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag, input int st, input int lv, input int pl,
                          input int fr, input int lo, input int wi);
        check({tag, ".state"},   32'(bus.state_dbg), 32'(st));
        check({tag, ".lives"},   32'(bus.lives),     32'(lv));
        check({tag, ".playing"}, 32'(bus.playing),   32'(pl));
        check({tag, ".freeze"},  32'(bus.freeze),    32'(fr));
        check({tag, ".loser"},   32'(bus.loser),     32'(lo));
        check({tag, ".winner"},  32'(bus.winner),    32'(wi));
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; step(); bus.start = 1'b0;
    endtask

    task automatic pulse_hit();
        bus.player_hit = 1'b1; step(); bus.player_hit = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1; step(); bus.frame_tick = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.frame_tick      = 1'b0;
        bus.start           = 1'b0;
        bus.player_hit      = 1'b0;
        bus.invaders_landed = 1'b0;
        bus.aliens_left     = 6'd10;
        #12;
        status("reset", 0, 3, 0, 1, 0, 0);
        #11 rst = 1'b1;
        step();
        status("idle_after_reset", 0, 3, 0, 1, 0, 0);

        // Inputs other than start are ignored in IDLE.
        pulse_hit();
        ticks(2);
        status("idle_ignore", 0, 3, 0, 1, 0, 0);

        pulse_start();
        status("start_play", 1, 3, 1, 0, 0, 0);

        pulse_hit();
        status("hit1", 2, 2, 0, 1, 0, 0);
        pulse_hit();
        status("hit_in_hit", 2, 2, 0, 1, 0, 0);
        ticks(3);
        status("hit_3ticks", 2, 2, 0, 1, 0, 0);
        ticks(1);
        status("hit_4ticks", 1, 2, 1, 0, 0, 0);

        pulse_hit();
        status("hit2", 2, 1, 0, 1, 0, 0);
        ticks(4);
        status("hit2_back", 1, 1, 1, 0, 0, 0);
        pulse_hit();
        status("hit3_lose", 3, 0, 0, 1, 1, 0);

        ticks(3);
        pulse_start();
        status("lose_early_start", 3, 0, 0, 1, 1, 0);
        ticks(5);
        pulse_start();
        status("lose_start_ok", 0, 0, 0, 1, 0, 0);

        // Win path and autorestart behaviour.
        pulse_start();
        status("play2", 1, 3, 1, 0, 0, 0);
        bus.aliens_left = 6'd0; step(); bus.aliens_left = 6'd10;
        status("win", 4, 3, 0, 1, 0, 1);
        ticks(11);
        status("win_11ticks", 4, 3, 0, 1, 0, 1);
        ticks(1);
`ifdef GAME_STATUS_AUTORESTART_EN
        status("win_autorestart", 0, 3, 0, 1, 0, 0);
        ticks(8);
        status("idle_after_auto", 0, 3, 0, 1, 0, 0);
`else
        status("win_12ticks", 4, 3, 0, 1, 0, 1);
        ticks(8);
        status("win_20ticks", 4, 3, 0, 1, 0, 1);
        pulse_start();
        status("win_start_ok", 0, 3, 0, 1, 0, 0);
`endif

        // Last-life hit coincident with aliens_left==0: hit path wins.
        pulse_start();
        pulse_hit();
        ticks(4);
        pulse_hit();
        ticks(4);
        status("one_life", 1, 1, 1, 0, 0, 0);
        bus.player_hit = 1'b1; bus.aliens_left = 6'd0;
        step();
        bus.player_hit = 1'b0; bus.aliens_left = 6'd10;
        status("hit_vs_win", 3, 0, 0, 1, 1, 0);
        ticks(8);
        pulse_start();
        status("idle3", 0, 0, 0, 1, 0, 0);

        // Tick coincident with entry to HIT is consumed by the clear.
        pulse_start();
        bus.player_hit = 1'b1; bus.frame_tick = 1'b1;
        step();
        bus.player_hit = 1'b0; bus.frame_tick = 1'b0;
        status("hit_tick_entry", 2, 2, 0, 1, 0, 0);
        ticks(3);
        status("hit_tick_3", 2, 2, 0, 1, 0, 0);

        // Landed during HIT overrides the timer; then async reset mid-LOSE.
        bus.invaders_landed = 1'b1; bus.frame_tick = 1'b1;
        step();
        bus.invaders_landed = 1'b0; bus.frame_tick = 1'b0;
        status("landed_in_hit", 3, 0, 0, 1, 1, 0);
        #2 rst = 1'b0;
        #1;
        status("async_reset", 0, 3, 0, 1, 0, 0);
        #3 rst = 1'b1;
        step();
        status("after_reset", 0, 3, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/game_status_ctrl.md
Name: game_status_ctrl

Overview:
- Top-level game-state sequencer for the VGA Space Invaders overlay path.
- Consumes gameplay events (player hit, invaders landed, alien count, start button) and frame ticks.
- Produces the `loser`/`winner` levels that drive the end-of-game text sprites, plus lives, playing and freeze controls for the motion blocks.
- Sits directly upstream of the loser/winner sprite generators.

Parameters:
- START_LIVES, 3, lives loaded on game start (1..3).
- HIT_FRAMES, 60, frames the player is frozen after a non-fatal hit.
- END_HOLD_FRAMES, 180, minimum frames LOSE/WIN is shown before start is accepted.
- AUTORESTART_FRAMES, 600, frames in LOSE/WIN before automatic return to IDLE (optional feature only; must be >= END_HOLD_FRAMES).
- ALIEN_CNT_W, 6, width of aliens_left.

Ports:
- clk  in  1  system clock (31.5 MHz pixel clock)
- rst  in  1  reset; asynchronous, active-low
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  debounced one-cycle start pulse
- player_hit  in  1  one-cycle pulse, alien missile hit player
- invaders_landed  in  1  level, alien formation reached player row
- aliens_left  in  ALIEN_CNT_W  live alien count
- playing  out  1  high in PLAY
- freeze  out  1  high in IDLE/HIT/LOSE/WIN; motion blocks hold position
- loser  out  1  high in LOSE
- winner  out  1  high in WIN
- lives  out  2  remaining lives
- state_dbg  out  3  encoded state

Behaviour:
- States: IDLE=0, PLAY=1, HIT=2, LOSE=3, WIN=4. Single registered state, plus lives register and frame counter fcnt.
- Outputs are a Moore decode of the state register. They change in the same clock edge as the state, i.e. one cycle after the triggering input is sampled.
- Reset (rst=0, async): state=IDLE, lives=START_LIVES, fcnt=0.
  - Outputs during and after reset: playing=0, freeze=1, loser=0, winner=0, state_dbg=0.
  - Reset mid-game aborts immediately; loser/winner drop without waiting for a clock.
- IDLE: start -> PLAY; lives<=START_LIVES; fcnt<=0. All other inputs ignored.
- PLAY, evaluated in priority order each cycle:
  1. invaders_landed -> LOSE, lives<=0.
  2. player_hit with lives==1 -> LOSE, lives<=0.
  3. player_hit with lives>1 -> HIT, lives<=lives-1, fcnt<=0.
  4. aliens_left==0 -> WIN.
  5. start is ignored.
- HIT:
  - fcnt increments on frame_tick.
  - On frame_tick with fcnt==HIT_FRAMES-1 -> PLAY, fcnt<=0.
  - player_hit ignored.
  - invaders_landed -> LOSE, lives<=0; this overrides the timer.
  - aliens_left==0 is not checked here; it takes effect on return to PLAY.
- LOSE / WIN:
  - On entry fcnt<=0. fcnt increments on frame_tick, saturating at the larger of END_HOLD_FRAMES and AUTORESTART_FRAMES.
  - start with fcnt>=END_HOLD_FRAMES -> IDLE, fcnt<=0.
  - start earlier is dropped, not latched.
  - lives holds its value.
- Simultaneous events:
  - landed+hit -> LOSE.
  - hit with aliens_left==0 -> hit path wins.
  - frame_tick coincident with a transition is consumed by the new state's counter clear (fcnt=0, not 1).
- Width rules:
  - fcnt width = $clog2(max(HIT_FRAMES, END_HOLD_FRAMES, AUTORESTART_FRAMES)+1).
  - lives never underflows below 0.
  - state_dbg is zero-extended from the state encoding.

Optional Feature:
- Macro: GAME_STATUS_AUTORESTART_EN.
- Defined: in LOSE/WIN, the frame_tick that brings fcnt to AUTORESTART_FRAMES forces -> IDLE (loser/winner drop), even with no start.
- Undefined: LOSE/WIN persist until an accepted start; AUTORESTART_FRAMES is unused.

Decomposition:
- Package game_pkg: game_state_t enum (3-bit, encodings above), LIVES_W=2, default lives/frame constants shared with the sprite blocks.
- Sub-module frame_timer:
  - Frame-tick counter with synchronous clear and saturation.
  - Terminal-compare outputs: hit_done, hold_done, auto_done.
  - Instantiated once.

Test Plan (HIT_FRAMES=4, END_HOLD_FRAMES=8, START_LIVES=3):
- Reset then start pulse -> next cycle playing=1, freeze=0, lives=3, state_dbg=1.
- player_hit in PLAY -> state HIT, lives=2, freeze=1; after 4 frame_ticks -> PLAY. A second player_hit during HIT leaves lives=2.
- Three hits across play (3->2->1->LOSE) -> loser=1, lives=0. start after 3 ticks ignored (loser stays 1); start after 8 ticks -> IDLE, loser=0.
- aliens_left=0 in PLAY -> winner=1; same cycle as player_hit with lives=1 -> loser=1, winner=0.
- invaders_landed asserted in HIT with lives=2 -> LOSE next cycle, lives=0; assert rst low mid-LOSE -> loser=0 asynchronously, state_dbg=0.
- With GAME_STATUS_AUTORESTART_EN, AUTORESTART_FRAMES=12: enter WIN, no start -> IDLE on 12th frame_tick. Without the macro -> still WIN after 20 ticks.
